// File: rtl/control_unit_register_file_sign_extend32.sv
// MIPS decode-stage core: main control decode, 32x32 register file with
// combinational reads and one write port, and the 16->32 immediate sign extender.
module control_unit_register_file_sign_extend32 (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [5:0]  opcode,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [15:0] immediate,
    input  logic [4:0]  finRD,
    input  logic        writeSig,
    input  logic [31:0] writeToReg,
    output logic [31:0] register1,
    output logic [31:0] register2,
    output logic [31:0] signExtend,
    output logic [8:0]  controlUnitSig
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    // Register 0 is forced to zero so it never holds anything but 0.
    always_comb begin
        regs_d = regs_q;
        if (writeSig && (finRD != 5'd0)) begin
            regs_d[finRD] = writeToReg;
        end
        regs_d[0] = 32'd0;
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Address 0 is decoded explicitly so reads stay defined even before reset.
    assign register1 = (rs == 5'd0) ? 32'd0 : regs_q[rs];
    assign register2 = (rt == 5'd0) ? 32'd0 : regs_q[rt];

    assign signExtend = {{16{immediate[15]}}, immediate};

    // Bit order: {RegDST, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, branch, AluOp[1:0]}
    always_comb begin
        controlUnitSig = 9'b0;
        case (opcode)
            OP_RTYPE: controlUnitSig = 9'b1_0010_0010;
            OP_LW:    controlUnitSig = 9'b0_1111_0000;
            OP_SW:    controlUnitSig = 9'b0_1000_1000;
            OP_BEQ:   controlUnitSig = 9'b0_0000_0101;
            OP_ADDI:  controlUnitSig = 9'b0_1010_0000;
            default:  controlUnitSig = 9'b0;
        endcase
    end

endmodule

// File: tb/tb_control_unit_register_file_sign_extend32.sv
// Directed bench for the decode-stage core: register file reset/write/read,
// no-bypass timing, register 0, sign extension and the control decode table.
module tb_control_unit_register_file_sign_extend32;

    logic        clk;
    logic        rst_n;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] immediate;
    logic [4:0]  fin_rd;
    logic        write_sig;
    logic [31:0] write_to_reg;
    logic [31:0] register1;
    logic [31:0] register2;
    logic [31:0] sign_extend;
    logic [8:0]  control_unit_sig;

    int error_count = 0;
    int check_count = 0;

    control_unit_register_file_sign_extend32 dut (
        .Clk            (clk),
        .Rst_n          (rst_n),
        .opcode         (opcode),
        .rs             (rs),
        .rt             (rt),
        .immediate      (immediate),
        .finRD          (fin_rd),
        .writeSig       (write_sig),
        .writeToReg     (write_to_reg),
        .register1      (register1),
        .register2      (register2),
        .signExtend     (sign_extend),
        .controlUnitSig (control_unit_sig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Drives inputs 1 time unit after a rising edge, well away from the next one.
    task automatic applyStimulus(input logic rst_v, input logic wr_v, input logic [4:0] rd_v,
                                 input logic [31:0] data_v, input logic [4:0] rs_v, input logic [4:0] rt_v);
        rst_n        = rst_v;
        write_sig    = wr_v;
        fin_rd       = rd_v;
        write_to_reg = data_v;
        rs           = rs_v;
        rt           = rt_v;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [5:0]  op_vec  [6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h3F};
    logic [8:0]  ctl_vec [6] = '{9'b1_0010_0010, 9'b0_1111_0000, 9'b0_1000_1000,
                                 9'b0_0000_0101, 9'b0_1010_0000, 9'b0_0000_0000};
    logic [15:0] imm_vec [5] = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000, 16'h1234};
    logic [31:0] ext_vec [5] = '{32'hFFFF8000, 32'h00007FFF, 32'hFFFFFFFF, 32'h00000000, 32'h00001234};

    initial begin
        opcode    = 6'h00;
        immediate = 16'h0000;
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        tick();

        // Reset clears every register.
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));
            checkOutput($sformatf("reset_r1[%0d]", i), register1, 32'd0);
            checkOutput($sformatf("reset_r2[%0d]", 31 - i), register2, 32'd0);
        end
        tick();

        // Write reg5; no bypass before the edge, visible right after.
        applyStimulus(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
        checkOutput("no_bypass_r1", register1, 32'd0);
        checkOutput("no_bypass_r2", register2, 32'd0);
        tick();
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
        checkOutput("write5_r1", register1, 32'hDEADBEEF);
        checkOutput("write5_r2", register2, 32'hDEADBEEF);

        // Highest address is independent of reg5.
        applyStimulus(1'b1, 1'b1, 5'd31, 32'h13579BDF, 5'd31, 5'd5);
        tick();
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 5'd31, 5'd5);
        checkOutput("write31_r1", register1, 32'h13579BDF);
        checkOutput("keep5_r2", register2, 32'hDEADBEEF);

        // Writes to reg0 are dropped.
        applyStimulus(1'b1, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0);
        tick();
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        checkOutput("reg0_r1", register1, 32'd0);
        checkOutput("reg0_r2", register2, 32'd0);

        // writeSig low: reg7 unchanged.
        applyStimulus(1'b1, 1'b0, 5'd7, 32'h0000FFFF, 5'd7, 5'd7);
        tick();
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 5'd7, 5'd5);
        checkOutput("nowrite7_r1", register1, 32'd0);
        checkOutput("nowrite7_keep5", register2, 32'hDEADBEEF);

        // Reset mid-operation overrides a concurrent write.
        applyStimulus(1'b1, 1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd3);
        tick();
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 5'd3, 5'd3);
        checkOutput("write3_r1", register1, 32'hA5A5A5A5);
        applyStimulus(1'b0, 1'b1, 5'd4, 32'h55AA55AA, 5'd3, 5'd4);
        tick();
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 5'd3, 5'd4);
        checkOutput("rst_reg3", register1, 32'd0);
        checkOutput("rst_reg4", register2, 32'd0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 5'd5, 5'd31);
        checkOutput("rst_reg5", register1, 32'd0);
        checkOutput("rst_reg31", register2, 32'd0);

        // Sign extension, checked with reset both high and low.
        for (int i = 0; i < 5; i++) begin
            immediate = imm_vec[i];
            #1;
            checkOutput($sformatf("sext_%04h", imm_vec[i]), sign_extend, ext_vec[i]);
        end
        rst_n     = 1'b0;
        immediate = 16'h8000;
        #1;
        checkOutput("sext_in_reset", sign_extend, 32'hFFFF8000);

        // Control decode, including an unknown opcode.
        for (int i = 0; i < 6; i++) begin
            opcode = op_vec[i];
            #1;
            checkOutput($sformatf("ctl_op_%02h", op_vec[i]), {23'd0, control_unit_sig}, {23'd0, ctl_vec[i]});
        end
        opcode = 6'h23;
        #1;
        checkOutput("ctl_in_reset", {23'd0, control_unit_sig}, {23'd0, 9'b0_1111_0000});
        rst_n = 1'b1;
        opcode = 6'h02;
        #1;
        checkOutput("ctl_op_02", {23'd0, control_unit_sig}, 32'd0);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
